// File: rtl/stack_sequencer_if.sv
// -----------------------------------------------------------------------------
// stack_sequencer_if
// Opcode issue channel between the stack sequencer and the execution unit.
//
// Handshake: the master raises op_valid with op_code and holds both stable
// until the slave answers with op_ready; the transfer completes on the first
// rising CLK edge where op_valid and op_ready are both high. op_ready may be
// high before op_valid rises. An asynchronous reset of the master may drop
// op_valid without a transfer.
//
// Signals:
//   op_valid  master -> slave  opcode offered
//   op_code   master -> slave  8-bit opcode, stable while op_valid=1
//   op_ready  slave  -> master slave accepts op_code this cycle
// -----------------------------------------------------------------------------
interface stack_sequencer_if;
   logic       op_valid;
   logic [7:0] op_code;
   logic       op_ready;

   modport master (output op_valid, output op_code, input op_ready);
   modport slave  (input op_valid, input op_code, output op_ready);
endinterface

// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
// Instruction sequencer of the stack processor. Owns the program counter and
// the step prescaler, fetches opcodes from the instruction ROM, retires control
// opcodes (0x00 nop, 11xxxxxx jump, 0xFF halt) internally and issues every
// other opcode to the execution unit over the op_if handshake. The whole block
// runs on CLK; the prescaler produces a one-cycle step tick.
//
// Optional feature macro: STACK_SEQUENCER_SINGLE_STEP_EN
//   When defined, adds input 'step': a step pulse while paused in WAIT_TICK
//   fetches the next instruction as if a tick had arrived.
//
// Parameters:
//   PC_W    program counter / ROM address width (1..6)
//   TICK_W  prescaler width; step period = 2^TICK_W CLK cycles
//
// Ports:
//   CLK          system clock
//   RST          asynchronous, active-high reset
//   start        one-cycle pulse; begins execution at address 0 (IDLE/HALT)
//   pause        level; while high, step ticks are ignored
//   step         (optional) single-step pulse, honoured only while paused
//   imem_addr    ROM address, equals the PC
//   imem_data    ROM word at imem_addr, combinational
//   op_if        opcode issue channel (master side)
//   running      high in WAIT_TICK, FETCH or ISSUE
//   halted       high in HALT
//   o_dbg_state  current FSM state (IDLE=0, WAIT_TICK=1, FETCH=2, ISSUE=3,
//                HALT=4)
// -----------------------------------------------------------------------------
module stack_sequencer #(
   parameter int PC_W   = 4,
   parameter int TICK_W = 22
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 pause,
`ifdef STACK_SEQUENCER_SINGLE_STEP_EN
   input  logic                 step,
`endif
   output logic [PC_W-1:0]      imem_addr,
   input  logic [7:0]           imem_data,
   stack_sequencer_if.master    op_if,
   output logic                 running,
   output logic                 halted,
   output logic [2:0]           o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_TICK = 3'd1,
      S_FETCH     = 3'd2,
      S_ISSUE     = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   state_t            r_state;
   logic [PC_W-1:0]   r_pc;
   logic [TICK_W-1:0] r_tick_cnt;
   logic              r_op_valid;
   logic [7:0]        r_op_code;
   logic              r_running;
   logic              r_halted;

   logic              w_tick;
   logic              w_advance;
   logic              w_is_halt;
   logic              w_is_nop;
   logic              w_is_jump;
   logic [PC_W-1:0]   w_pc_inc;
   logic              w_start_ok;

   // Tick is the last count of the period; the counter wraps on the next edge.
   assign w_tick = &r_tick_cnt;

`ifdef STACK_SEQUENCER_SINGLE_STEP_EN
   assign w_advance = (w_tick & ~pause) | (pause & step);
`else
   assign w_advance = w_tick & ~pause;
`endif

   // Halt is tested first: 0xFF also matches the 11xxxxxx jump pattern.
   assign w_is_halt  = (imem_data == 8'hFF);
   assign w_is_nop   = (imem_data == 8'h00);
   assign w_is_jump  = (imem_data[7:6] == 2'b11);
   assign w_pc_inc   = r_pc + PC_W'(1);
   assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_HALT));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_tick_cnt <= '0;
         r_op_valid <= 1'b0;
         r_op_code  <= 8'h00;
         r_running  <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         // Prescaler free-runs while the machine runs, including FETCH/ISSUE,
         // so ticks landing there are simply lost rather than queued.
         if (w_start_ok) begin
            r_tick_cnt <= '0;
         end else if (r_running) begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
         end

         case (r_state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  r_pc      <= '0;
                  r_state   <= S_WAIT_TICK;
                  r_running <= 1'b1;
                  r_halted  <= 1'b0;
               end
            end

            S_WAIT_TICK: begin
               if (w_advance) begin
                  r_state <= S_FETCH;
               end
            end

            S_FETCH: begin
               if (w_is_halt) begin
                  r_state   <= S_HALT;
                  r_running <= 1'b0;
                  r_halted  <= 1'b1;
               end else if (w_is_nop) begin
                  r_pc    <= w_pc_inc;
                  r_state <= S_WAIT_TICK;
               end else if (w_is_jump) begin
                  r_pc    <= imem_data[PC_W-1:0];
                  r_state <= S_WAIT_TICK;
               end else begin
                  r_op_code  <= imem_data;
                  r_op_valid <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (op_if.op_ready) begin
                  r_op_valid <= 1'b0;
                  r_pc       <= w_pc_inc;
                  r_state    <= S_WAIT_TICK;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_op_valid <= 1'b0;
               r_running  <= 1'b0;
               r_halted   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr      = r_pc;
   assign op_if.op_valid = r_op_valid;
   assign op_if.op_code  = r_op_code;
   assign running        = r_running;
   assign halted         = r_halted;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_stack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_sequencer
// Bench for stack_sequencer. Instance A (PC_W=4, TICK_W=3) is followed by a
// behavioural model every cycle; instance B (PC_W=2, TICK_W=2) covers PC wrap.
// Edge E0 is the rising edge that samples a start pulse; "after Ek" means
// 1 time unit after the k-th rising edge following E0.
// -----------------------------------------------------------------------------
module tb_stack_sequencer;

   localparam int PER_A = 8;

   logic       CLK;
   logic       RST;
   logic       start;
   logic       pause;
   logic       start_b;
`ifdef STACK_SEQUENCER_SINGLE_STEP_EN
   logic       step;
   logic       step_b;
`endif

   logic [3:0] imem_addr_a;
   logic [7:0] imem_data_a;
   logic       running_a;
   logic       halted_a;
   logic [2:0] dbg_a;

   logic [1:0] imem_addr_b;
   logic [7:0] imem_data_b;
   logic       running_b;
   logic       halted_b;
   logic [2:0] dbg_b;

   logic [7:0] rom_a [16];
   logic [7:0] rom_b [4];

   stack_sequencer_if ifa ();
   stack_sequencer_if ifb ();

   assign imem_data_a = rom_a[imem_addr_a];
   assign imem_data_b = rom_b[imem_addr_b];

   stack_sequencer #(.PC_W(4), .TICK_W(3)) u_dut_a (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .pause       (pause),
`ifdef STACK_SEQUENCER_SINGLE_STEP_EN
      .step        (step),
`endif
      .imem_addr   (imem_addr_a),
      .imem_data   (imem_data_a),
      .op_if       (ifa),
      .running     (running_a),
      .halted      (halted_a),
      .o_dbg_state (dbg_a)
   );

   stack_sequencer #(.PC_W(2), .TICK_W(2)) u_dut_b (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start_b),
      .pause       (1'b0),
`ifdef STACK_SEQUENCER_SINGLE_STEP_EN
      .step        (step_b),
`endif
      .imem_addr   (imem_addr_b),
      .imem_data   (imem_data_b),
      .op_if       (ifb),
      .running     (running_b),
      .halted      (halted_b),
      .o_dbg_state (dbg_b)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int t0      = 0;

   // ---------------- behavioural model of instance A ----------------
   // m_phase: 0 idle, 1 waiting for a step tick, 2 fetching, 3 offering, 4 halted
   int         m_phase = 0;
   int         m_pc    = 0;
   int         m_cnt   = 0;
   logic [7:0] m_code  = 8'h00;

   task automatic model_update();
      int         prev;
      bit         tick;
      bit         adv;
      bit         started;
      logic [7:0] d;
      if (RST) begin
         m_phase = 0;
         m_pc    = 0;
         m_cnt   = 0;
         m_code  = 8'h00;
      end else begin
         prev    = m_phase;
         tick    = (m_cnt == PER_A - 1);
         adv     = tick && !pause;
`ifdef STACK_SEQUENCER_SINGLE_STEP_EN
         adv     = adv || (pause && step);
`endif
         started = 1'b0;
         case (m_phase)
            0, 4: if (start) begin
               m_pc = 0; m_cnt = 0; m_phase = 1; started = 1'b1;
            end
            1: if (adv) m_phase = 2;
            2: begin
               d = rom_a[m_pc];
               if (d == 8'hFF) m_phase = 4;
               else if (d == 8'h00) begin m_pc = (m_pc + 1) % 16; m_phase = 1; end
               else if (d >= 8'hC0) begin m_pc = d % 16; m_phase = 1; end
               else begin m_code = d; m_phase = 3; end
            end
            3: if (ifa.op_ready) begin m_pc = (m_pc + 1) % 16; m_phase = 1; end
            default: ;
         endcase
         if (prev >= 1 && prev <= 3 && !started) m_cnt = (m_cnt + 1) % PER_A;
      end
   endtask

   // ---------------- compare process ----------------
   always @(posedge CLK) begin
      #1;
      model_update();
      n_tests++;
      if (ifa.op_valid !== (m_phase == 3) || ifa.op_code !== m_code ||
          imem_addr_a !== 4'(m_pc) || running_a !== (m_phase >= 1 && m_phase <= 3) ||
          halted_a !== (m_phase == 4)) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t: got valid=%0b code=%02h addr=%0d run=%0b halt=%0b, expected valid=%0b code=%02h addr=%0d run=%0b halt=%0b",
                  $time, ifa.op_valid, ifa.op_code, imem_addr_a, running_a, halted_a,
                  (m_phase == 3), m_code, m_pc, (m_phase >= 1 && m_phase <= 3), (m_phase == 4));
      end
   end

   // ---------------- driver / directed check tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge CLK); start = 1'b1;
      @(negedge CLK); start = 1'b0; t0 = cyc;
   endtask

   task automatic at_edge(input int k);
      while (cyc < t0 + k) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic load_rom(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
      for (int i = 0; i < 16; i++) rom_a[i] = 8'h00;
      rom_a[0] = w0; rom_a[1] = w1; rom_a[2] = w2; rom_a[3] = w3;
   endtask

   // ---------------- scoreboard for the wrap test ----------------
   logic [1:0] exp_q[$];
   logic [1:0] got_q[$];

   initial begin
      RST = 1'b1; start = 1'b0; pause = 1'b0; start_b = 1'b0;
`ifdef STACK_SEQUENCER_SINGLE_STEP_EN
      step = 1'b0; step_b = 1'b0;
`endif
      ifa.op_ready = 1'b1;
      ifb.op_ready = 1'b1;
      load_rom(8'h02, 8'h03, 8'h00, 8'hFF);
      for (int i = 0; i < 4; i++) rom_b[i] = 8'h02;

      // reset state
      repeat (3) @(negedge CLK);
      check("rst_valid",   ifa.op_valid, 0);
      check("rst_code",    ifa.op_code,  8'h00);
      check("rst_addr",    imem_addr_a,  0);
      check("rst_running", running_a,    0);
      check("rst_halted",  halted_a,     0);
      check("rst_state",   dbg_a,        0);
      RST = 1'b0;

      // 1: two issues 8 cycles apart, nop, halt
      pulse_start();
      at_edge(8);  check("t1_no_valid_e8", ifa.op_valid, 0);
      at_edge(9);  check("t1_valid_e9", ifa.op_valid, 1); check("t1_code_e9", ifa.op_code, 8'h02);
      at_edge(10); check("t1_drop_e10", ifa.op_valid, 0);
      at_edge(17); check("t1_valid_e17", ifa.op_valid, 1); check("t1_code_e17", ifa.op_code, 8'h03);
      at_edge(25); check("t1_nop_no_valid", ifa.op_valid, 0); check("t1_addr_e25", imem_addr_a, 3);
      at_edge(32); check("t1_not_halted_e32", halted_a, 0);
      at_edge(33); check("t1_halted", halted_a, 1); check("t1_running", running_a, 0);
      check("t1_halt_addr", imem_addr_a, 3); check("t1_code_kept", ifa.op_code, 8'h03);

      // 2: jump back to 0, 0x02 every 16 cycles
      rom_a[1] = 8'hC0;
      pulse_start();
      at_edge(9);  check("t2_valid_e9", ifa.op_valid, 1); check("t2_code_e9", ifa.op_code, 8'h02);
      at_edge(17); check("t2_jump_addr", imem_addr_a, 0);
      at_edge(25); check("t2_valid_e25", ifa.op_valid, 1); check("t2_code_e25", ifa.op_code, 8'h02);
      at_edge(41); check("t2_valid_e41", ifa.op_valid, 1); check("t2_addr_e41", imem_addr_a, 0);
      @(negedge CLK); rom_a[1] = 8'hFF;
      at_edge(50); check("t2_halted", halted_a, 1); check("t2_halt_addr", imem_addr_a, 1);

      // 3: op_ready low for 20+ cycles in ISSUE
      load_rom(8'h02, 8'h03, 8'h00, 8'hFF);
      ifa.op_ready = 1'b0;
      pulse_start();
      at_edge(9);  check("t3_valid_e9", ifa.op_valid, 1);
      at_edge(29); check("t3_valid_e29", ifa.op_valid, 1); check("t3_code_e29", ifa.op_code, 8'h02);
      check("t3_addr_e29", imem_addr_a, 0);
      @(negedge CLK); ifa.op_ready = 1'b1;
      at_edge(30); check("t3_addr_e30", imem_addr_a, 1); check("t3_drop_e30", ifa.op_valid, 0);
      at_edge(33); check("t3_valid_e33", ifa.op_valid, 1); check("t3_code_e33", ifa.op_code, 8'h03);
      at_edge(50); check("t3_halted", halted_a, 1);

      // 4: pause across two ticks
      pause = 1'b1;
      pulse_start();
      at_edge(16); check("t4_paused_addr", imem_addr_a, 0); check("t4_paused_valid", ifa.op_valid, 0);
      check("t4_paused_state", dbg_a, 1);
      @(negedge CLK); pause = 1'b0;
      at_edge(25); check("t4_valid_e25", ifa.op_valid, 1); check("t4_code_e25", ifa.op_code, 8'h02);
      @(negedge CLK); pause = 1'b1;
`ifdef STACK_SEQUENCER_SINGLE_STEP_EN
      at_edge(28);
      @(negedge CLK); step = 1'b1;
      @(negedge CLK); step = 1'b0;
      at_edge(30); check("t4_step_valid", ifa.op_valid, 1); check("t4_step_code", ifa.op_code, 8'h03);
      at_edge(40); check("t4_step_once_addr", imem_addr_a, 2); check("t4_step_once_valid", ifa.op_valid, 0);
`else
      at_edge(40); check("t4_hold_addr", imem_addr_a, 1); check("t4_hold_valid", ifa.op_valid, 0);
`endif
      @(negedge CLK); pause = 1'b0;
      at_edge(90); check("t4_halted", halted_a, 1);

      // 5: async reset while offering
      load_rom(8'h00, 8'h05, 8'hFF, 8'hFF);
      ifa.op_ready = 1'b0;
      pulse_start();
      at_edge(17); check("t5_valid_e17", ifa.op_valid, 1); check("t5_addr_e17", imem_addr_a, 1);
      #1; RST = 1'b1;
      #1; check("t5_rst_valid", ifa.op_valid, 0); check("t5_rst_addr", imem_addr_a, 0);
      check("t5_rst_state", dbg_a, 0); check("t5_rst_running", running_a, 0);
      @(negedge CLK);
      @(negedge CLK); RST = 1'b0;
      pulse_start();
      at_edge(8);  check("t5_restart_addr", imem_addr_a, 0);
      at_edge(17); check("t5_restart_valid", ifa.op_valid, 1); check("t5_restart_code", ifa.op_code, 8'h05);
      @(negedge CLK); ifa.op_ready = 1'b1;
      at_edge(30); check("t5_halted", halted_a, 1); check("t5_halt_addr", imem_addr_a, 2);

      // 6: PC wrap on the PC_W=2 instance
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      @(negedge CLK); start_b = 1'b1;
      @(negedge CLK); start_b = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         @(posedge CLK); #1;
         if (ifb.op_valid) got_q.push_back(imem_addr_b);
      end
      check("t6_issue_count", got_q.size(), 5);
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("t6_addr_%0d", i), (i < got_q.size()) ? got_q[i] : 2'bxx, exp_q[i]);
      end

      @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
